// File: rtl/serial_word_scanner_if.sv
// rtl/serial_word_scanner_if.sv - word-in / bit-out handshake bundle for the serial word scanner
interface serial_word_scanner_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic [2:0] sel;
    logic       busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_last, sel, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_last, sel, busy
    );
endinterface

// File: rtl/serial_word_scanner.sv
// rtl/serial_word_scanner.sv - holds an 8-bit word and scans it out one selected bit per beat
module serial_word_scanner #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_word_scanner_if.slave  sws
);
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] IDX_START = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state, state_nx;
    logic [7:0] held_word, held_word_nx;
    logic [2:0] idx, idx_nx;
    logic [2:0] cnt, cnt_nx;
    logic       last;
    logic       accept;
    logic       xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            held_word <= 8'd0;
            idx       <= 3'd0;
            cnt       <= 3'd0;
        end else begin
            state     <= state_nx;
            held_word <= held_word_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        held_word_nx  = held_word;
        idx_nx        = idx;
        cnt_nx        = cnt;
        sws.out_valid = 1'b0;
        sws.busy      = 1'b0;
        sws.sel       = 3'd0;
        sws.out_bit   = 1'b0;
        sws.out_last  = 1'b0;
        last          = 1'b0;

        if (state == SHIFT) begin
            last          = (cnt == 3'd7);
            sws.out_valid = !reset;
            sws.busy      = 1'b1;
            sws.sel       = idx;
            sws.out_bit   = held_word[idx];
            sws.out_last  = last;
        end

        // Accepting on the last-beat edge is what makes back-to-back words bubble-free.
        sws.in_ready = !reset && ((state == IDLE) || (last && sws.out_ready));
        accept       = sws.in_valid && sws.in_ready;
        xfer         = sws.out_valid && sws.out_ready;

        if (accept) begin
            held_word_nx = sws.in_data;
            cnt_nx       = 3'd0;
            idx_nx       = IDX_START;
            state_nx     = SHIFT;
        end else if (xfer) begin
            if (last) begin
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt + 3'd1;
                idx_nx = MSB_FIRST ? (idx - 3'd1) : (idx + 3'd1);
            end
        end
    end
endmodule
